freq_div_ctrl: RTL and testbench
================================

# freq_div_ctrl

- Runtime-programmable clock-enable divider controller: start/stop, programmable half-period, glitch-free ratio updates.
- Produces `div_out`, a 50 % duty square wave with period 2×H `clk` cycles.
- Accepts new half-period values through a valid/ready port and applies them only at toggle boundaries.
- Sits between the configuration/control logic and every consumer of divided timing.

## Interface
- `W`, 16: width of half-period values.
- `DEFAULT_HALF`, 2: half-period H loaded at reset; must be ≥1.
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  level-sampled request to begin dividing.
- `stop`  in  1  level-sampled request to end dividing at the next low phase.
- `cfg_valid`  in  1  new half-period offered.
- `cfg_half`  in  W  offered half-period in `clk` cycles; 0 is illegal.
- `cfg_ready`  out  1  controller can accept a value.
- `cfg_err`  out  1  one-cycle pulse: a value of 0 was accepted and discarded.
- `div_out`  out  1  divided output.
- `tick`  out  1  one-cycle pulse in the cycle `div_out` changes.
- `busy`  out  1  high in RUN and STOPPING.

## Operation
- Reset values:
  - `div_out`=0, `tick`=0, `busy`=0, `cfg_ready`=1, `cfg_err`=0.
  - Active half H=`DEFAULT_HALF`, no pending value, counter=0, state IDLE.
- States: IDLE, RUN, STOPPING.
- IDLE:
  - `div_out`=0, counter held at 0.
  - `start`=1 & `stop`=0 → RUN, counter=0.
  - `start`=1 & `stop`=1 → stay IDLE; stop wins.
- RUN / STOPPING counting:
  - Counter increments each cycle.
  - When counter==H-1: counter←0, `div_out` toggles, `tick`=1, and a pending value (if any) becomes H.
- RUN transitions:
  - `stop`=1 → STOPPING.
  - `start` is ignored.
- STOPPING:
  - Counting continues.
  - The toggle that drives `div_out` 1→0 returns the block to IDLE in the same edge.
  - If `div_out` is already 0 when stop is taken, the block finishes the current low phase, runs one full high phase, then stops on the falling toggle.
  - Result: the output always ends low with no runt pulse.
  - `start`=1 (without `stop`) → back to RUN; counter and `div_out` are undisturbed.
- Configuration handshake:
  - Transfer occurs when `cfg_valid` & `cfg_ready`.
  - Nonzero value: stored as pending, `cfg_ready`=0 until it is applied.
  - Value 0: discarded, `cfg_err`=1 for one cycle, `cfg_ready` stays 1.
- When a pending value is applied:
  - In IDLE: on the next edge.
  - In RUN/STOPPING: at the next toggle.
  - A transfer in the same cycle as a toggle applies at the following toggle, never the current one.
- Counter width is W bits; H ≤ 2^W−1, so no overflow is possible.

## Timing
- `start` sampled at edge t → `busy`=1 after t; first rising toggle at edge t+H; period 2H thereafter.
- H=1 gives `div_out` = clk/2.
- Updates are registered; no combinational path from inputs to `div_out` or `tick`.
- `cfg_ready` is registered and falls the cycle after a transfer.
- Reset mid-operation: all state returns to reset values immediately; any pending value is lost.

## Configuration
- Macro: `FREQ_DIV_CTRL_CYCLE_CNT_EN`.
- Defined:
  - Adds output `cycle_cnt` [15:0], reset 0.
  - Increments on every 1→0 toggle of `div_out` and wraps 0xFFFF→0.
  - Clears to 0 in the cycle RUN is entered from IDLE.
- Undefined: the port and its logic are absent; all other behaviour is identical.

## Test plan
- Reset, then `start` with default H=2 → `div_out` rises 2 cycles after start, period 4, `tick` on every change, `busy`=1.
- In RUN with H=3, send `cfg_half`=5 mid-high-phase:
  - current phase completes at 3 cycles;
  - following phases are 5 cycles;
  - `cfg_ready` low from the transfer until that toggle.
- `cfg_half`=0 → `cfg_err` pulses once, H unchanged, `cfg_ready` stays 1.
- `stop` asserted 1 cycle into a low phase with H=4 → one full 4-cycle high phase, falling toggle, `busy`=0, `div_out`=0.
- `start`=`stop`=1 in IDLE → remains IDLE. `start` during STOPPING → returns to RUN with no phase glitch.
- Assert `rst` mid-high phase with a pending value → outputs reset at once; after restart H=`DEFAULT_HALF`. With macro defined, `cycle_cnt` counts 3 after 3 full periods.

Source files
------------

// File: rtl/freq_div_ctrl.sv
// freq_div_ctrl: programmable 50% clock-enable divider with start/stop and glitch-free ratio updates.
// Define FREQ_DIV_CTRL_CYCLE_CNT_EN to add the cycle_cnt output counting completed periods.
module freq_div_ctrl #(
   parameter int W            = 16,
   parameter int DEFAULT_HALF = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         stop,
   input  logic         cfg_valid,
   input  logic [W-1:0] cfg_half,
   output logic         cfg_ready,
   output logic         cfg_err,
   output logic         div_out,
   output logic         tick,
`ifdef FREQ_DIV_CTRL_CYCLE_CNT_EN
   output logic [15:0]  cycle_cnt,
`endif
   output logic         busy
);
   typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;
   state_t state_q, state_d;
   logic [W-1:0] cnt_q, cnt_d, half_q, half_d, pend_q, pend_d;
   logic pend_vld_q, pend_vld_d, div_q, div_d, tick_q, tick_d, err_q, err_d;
   logic running, tog, xfer;
   always_comb begin
      running    = state_q != IDLE;
      tog        = running && cnt_q == half_q - W'(1);
      xfer       = cfg_valid && !pend_vld_q;
      state_d    = state_q;
      cnt_d      = running ? (tog ? '0 : cnt_q + W'(1)) : '0;
      div_d      = running ? div_q ^ tog : 1'b0;
      tick_d     = tog;
      half_d     = half_q;
      pend_d     = pend_q;
      pend_vld_d = pend_vld_q;
      err_d      = xfer && cfg_half == '0;
      if (pend_vld_q && (!running || tog)) begin
         half_d     = pend_q;
         pend_vld_d = 1'b0;
      end
      // a pending slot and an open ready are exclusive, so apply and capture never collide
      if (xfer && cfg_half != '0) begin
         pend_d     = cfg_half;
         pend_vld_d = 1'b1;
      end
      case (state_q)
         IDLE:    if (start && !stop) state_d = RUN;
         RUN:     if (stop) state_d = STOPPING;
         default: if (tog && div_q) state_d = IDLE;
                  else if (start && !stop) state_d = RUN;
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         half_q     <= W'(DEFAULT_HALF);
         pend_q     <= '0;
         pend_vld_q <= 1'b0;
         div_q      <= 1'b0;
         tick_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         half_q     <= half_d;
         pend_q     <= pend_d;
         pend_vld_q <= pend_vld_d;
         div_q      <= div_d;
         tick_q     <= tick_d;
         err_q      <= err_d;
      end
   end
   assign cfg_ready = !pend_vld_q;
   assign cfg_err   = err_q;
   assign div_out   = div_q;
   assign tick      = tick_q;
   assign busy      = running;
`ifdef FREQ_DIV_CTRL_CYCLE_CNT_EN
   logic [15:0] cyc_q, cyc_d;
   always_comb begin
      cyc_d = (state_q == IDLE && state_d == RUN) ? 16'd0 : (tog && div_q) ? cyc_q + 16'd1 : cyc_q;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) cyc_q <= 16'd0;
      else     cyc_q <= cyc_d;
   end
   assign cycle_cnt = cyc_q;
`endif
endmodule

// File: tb/tb_freq_div_ctrl.sv
// tb_freq_div_ctrl: directed and randomized checks of freq_div_ctrl against a phase-countdown model.
module tb_freq_div_ctrl;
   localparam int W = 16;
   logic clk = 1'b0, rst = 1'b0, start = 1'b0, stop = 1'b0, cfg_valid = 1'b0;
   logic [W-1:0] cfg_half = '0;
   logic cfg_ready, cfg_err, div_out, tick, busy;
`ifdef FREQ_DIV_CTRL_CYCLE_CNT_EN
   logic [15:0] cycle_cnt;
`endif
   int total = 0, bad = 0;
   int cyc = 0, last_tick = 0, phase_len = 0;
   // model: mode 0 idle, 1 run, 2 stopping; m_left counts edges until the next toggle
   int m_mode, m_left, m_half, m_pend, m_div, m_tick, m_err, m_cyc;

   always #5 clk = ~clk;

   freq_div_ctrl #(.W(W), .DEFAULT_HALF(2)) dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop),
      .cfg_valid(cfg_valid), .cfg_half(cfg_half), .cfg_ready(cfg_ready), .cfg_err(cfg_err),
      .div_out(div_out), .tick(tick),
`ifdef FREQ_DIV_CTRL_CYCLE_CNT_EN
      .cycle_cnt(cycle_cnt),
`endif
      .busy(busy)
   );

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
      end
   endtask

   task automatic model_reset;
      m_mode = 0; m_left = 0; m_half = 2; m_pend = 0;
      m_div = 0; m_tick = 0; m_err = 0; m_cyc = 0;
   endtask

   task automatic model_step;
      int was_mode = m_mode;
      int was_pend = m_pend;
      bit fell = 1'b0;
      m_tick = 0;
      m_err = int'(cfg_valid && was_pend == 0 && cfg_half == 0);
      if (was_mode == 0) begin
         if (was_pend != 0) begin m_half = was_pend; m_pend = 0; end
         m_div = 0;
         if (start && !stop) begin m_mode = 1; m_left = m_half; m_cyc = 0; end
      end else begin
         m_left--;
         if (m_left == 0) begin
            m_tick = 1;
            m_div = 1 - m_div;
            fell = (m_div == 0);
            if (was_pend != 0) begin m_half = was_pend; m_pend = 0; end
            m_left = m_half;
            if (fell) m_cyc = (m_cyc + 1) % 65536;
         end
         if (was_mode == 2 && fell) m_mode = 0;
         else if (was_mode == 1 && stop) m_mode = 2;
         else if (was_mode == 2 && start && !stop) m_mode = 1;
      end
      if (cfg_valid && was_pend == 0 && cfg_half != 0) m_pend = int'(cfg_half);
   endtask

   task automatic compare;
      chk("div_out", div_out, m_div);
      chk("tick", tick, m_tick);
      chk("busy", busy, int'(m_mode != 0));
      chk("cfg_ready", cfg_ready, int'(m_pend == 0));
      chk("cfg_err", cfg_err, m_err);
`ifdef FREQ_DIV_CTRL_CYCLE_CNT_EN
      chk("cycle_cnt", cycle_cnt, m_cyc);
`endif
   endtask

   task automatic step(input bit s, input bit p, input bit v, input int h);
      start = s; stop = p; cfg_valid = v; cfg_half = W'(h);
      @(posedge clk);
      model_step();
      #1;
      cyc++;
      compare();
      if (tick) begin phase_len = cyc - last_tick; last_tick = cyc; end
   endtask

   task automatic do_reset;
      #2;
      rst = 1'b1; start = 1'b0; stop = 1'b0; cfg_valid = 1'b0;
      #1;
      model_reset();
      compare();
      @(posedge clk);
      #1;
      compare();
      rst = 1'b0;
   endtask

   task automatic wait_tick(input string name);
      int n = 0;
      do begin step(0, 0, 0, 0); n++; end while (!tick && n < 40);
      chk(name, tick, 1);
   endtask

   initial begin
      int n;
      // default ratio after reset
      do_reset();
      chk("rst_div", div_out, 0);
      chk("rst_ready", cfg_ready, 1);
      chk("rst_busy", busy, 0);
      step(1, 0, 0, 0);
      chk("start_busy", busy, 1);
      chk("start_div", div_out, 0);
      for (int i = 1; i <= 8; i++) begin
         step(0, 0, 0, 0);
         chk("dflt_div", div_out, (i / 2) % 2);
         chk("dflt_tick", tick, int'(i % 2 == 0));
      end
      chk("dflt_period", phase_len, 2);

      // ratio update mid-high phase
      do_reset();
      step(0, 0, 1, 3);
      chk("idle_pend_ready", cfg_ready, 0);
      step(0, 0, 0, 0);
      chk("idle_apply_ready", cfg_ready, 1);
      step(1, 0, 0, 0);
      n = 0;
      do begin step(0, 0, 0, 0); n++; end while (!div_out && n < 20);
      chk("h3_rise_delay", n, 3);
      step(0, 0, 1, 5);
      chk("upd_ready_low", cfg_ready, 0);
      wait_tick("upd_tick1");
      chk("upd_old_phase", phase_len, 3);
      chk("upd_ready_back", cfg_ready, 1);
      wait_tick("upd_tick2");
      chk("upd_new_phase", phase_len, 5);

      // zero value rejected
      step(0, 0, 1, 0);
      chk("zero_err", cfg_err, 1);
      chk("zero_ready", cfg_ready, 1);
      step(0, 0, 0, 0);
      chk("zero_err_clear", cfg_err, 0);
      wait_tick("zero_tick");
      chk("zero_keep_half", phase_len, 5);

      // stop one cycle into a low phase with H=4
      step(0, 0, 1, 4);
      wait_tick("h4_tick_a");
      wait_tick("h4_tick_b");
      n = 0;
      do begin step(0, 0, 0, 0); n++; end while (!(tick && !div_out) && n < 40);
      chk("h4_fall_found", int'(tick && !div_out), 1);
      step(0, 1, 0, 0);
      chk("stop_busy", busy, 1);
      n = 0;
      while (busy && n < 30) begin step(0, 0, 0, 0); n++; end
      chk("stop_latency", n, 7);
      chk("stop_high_len", phase_len, 4);
      chk("stop_div_low", div_out, 0);

      // start with stop in idle, then restart during STOPPING
      step(1, 1, 0, 0);
      chk("startstop_idle", busy, 0);
      step(1, 0, 0, 0);
      step(0, 0, 0, 0);
      step(0, 1, 0, 0);
      step(1, 0, 0, 0);
      wait_tick("resume_tick1");
      wait_tick("resume_tick2");
      chk("resume_phase", phase_len, 4);
      wait_tick("resume_tick3");
      chk("resume_phase2", phase_len, 4);
      chk("resume_busy", busy, 1);

      // reset mid-high phase with a pending value
      n = 0;
      do begin step(0, 0, 0, 0); n++; end while (!(tick && div_out) && n < 40);
      step(0, 0, 1, 7);
      step(0, 0, 0, 0);
      do_reset();
      chk("mid_rst_div", div_out, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_ready", cfg_ready, 1);
      step(1, 0, 0, 0);
      n = 0;
      do begin step(0, 0, 0, 0); n++; end while (!div_out && n < 20);
      chk("post_rst_rise", n, 2);
      for (int i = 0; i < 5; i++) wait_tick("post_rst_tick");
`ifdef FREQ_DIV_CTRL_CYCLE_CNT_EN
      chk("cycle_cnt_3", cycle_cnt, 3);
`endif

      // randomized traffic against the model
      do_reset();
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 599) == 0) do_reset();
         step($urandom_range(0, 7) == 0, $urandom_range(0, 11) == 0,
              $urandom_range(0, 3) == 0, int'($urandom_range(0, 5)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
